// File: rtl/keccak_pkg.sv
// Shared constants, step indices and FSM encoding for the Keccak round sequencer.
package keccak_pkg;

    localparam int NUM_ROUNDS = 24;
    localparam int NUM_STEPS  = 5;
    localparam int ROUND_W    = 5;
    localparam int STEP_W     = 3;

    localparam logic [STEP_W-1:0] STEP_THETA = 3'd0;
    localparam logic [STEP_W-1:0] STEP_RHO   = 3'd1;
    localparam logic [STEP_W-1:0] STEP_PI    = 3'd2;
    localparam logic [STEP_W-1:0] STEP_CHI   = 3'd3;
    localparam logic [STEP_W-1:0] STEP_IOTA  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_ARM   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_LOAD  = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_t;

    // One-hot start vector for the given step unit.
    function automatic logic [NUM_STEPS-1:0] step_onehot(input logic [STEP_W-1:0] step);
        step_onehot = NUM_STEPS'(1) << step;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo up-counter with synchronous clear/enable and a terminal-count flag.
module mod_counter #(
    parameter int W   = 3,
    parameter int MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         tc
);

    assign tc = (count == W'(MAX));

    // Count 0..MAX and wrap; clear wins over enable.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tc ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/keccak_round_sequencer.sv
// Round/step sequencer for the slice-serial Keccak-f core: issues each step
// unit in order, waits for it, then strobes the state register.
//
// state | meaning
// IDLE  | ready high, waiting for start
// ISSUE | one-cycle start pulse to the current step unit
// ARM   | ignore the stale ready the unit shows while accepting start
// WAIT  | wait for the current unit's ready
// LOAD  | load state register from current step, advance step/round
// DONE  | one-cycle completion pulse
module keccak_round_sequencer
    import keccak_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 ready,
    output logic [NUM_STEPS-1:0] stepStart,
    input  logic [NUM_STEPS-1:0] stepReady,
    output logic [ROUND_W-1:0]   round,
    output logic [STEP_W-1:0]    selStep,
    output logic                 ldState,
    output logic                 done
);

    seq_state_t          state;
    logic [STEP_W-1:0]   step;
    logic                step_tc;
    logic                round_tc;
    logic                accept;
    logic                step_adv;
    logic                round_adv;

    assign accept    = (state == ST_IDLE) && start;
    assign step_adv  = (state == ST_LOAD);
    // Round only advances on a wrap that is not the last one; it then holds
    // at NUM_ROUNDS-1 through Done and Idle until the next accept.
    assign round_adv = step_adv && step_tc && !round_tc;
    assign selStep   = step;

    mod_counter #(
        .W   (STEP_W),
        .MAX (NUM_STEPS - 1)
    ) u_step_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable (step_adv),
        .count  (step),
        .tc     (step_tc)
    );

    mod_counter #(
        .W   (ROUND_W),
        .MAX (NUM_ROUNDS - 1)
    ) u_round_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable (round_adv),
        .count  (round),
        .tc     (round_tc)
    );

    // State transitions with outputs registered for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ready     <= 1'b1;
            stepStart <= '0;
            ldState   <= 1'b0;
            done      <= 1'b0;
        end else begin
            stepStart <= '0;
            ldState   <= 1'b0;
            done      <= 1'b0;
            ready     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_ISSUE;
                        stepStart <= step_onehot(STEP_THETA);
                    end else begin
                        ready <= 1'b1;
                    end
                end
                ST_ISSUE: state <= ST_ARM;
                ST_ARM:   state <= ST_WAIT;
                ST_WAIT: begin
                    if (stepReady[step]) begin
                        state   <= ST_LOAD;
                        ldState <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (step_tc && round_tc) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= ST_ISSUE;
                        stepStart <= step_onehot(step_tc ? STEP_THETA : step + STEP_W'(1));
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_round_sequencer.sv
// Scoreboard bench for keccak_round_sequencer with behavioural step units.
module tb_keccak_round_sequencer;
    import keccak_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 ready;
    logic [NUM_STEPS-1:0] stepStart;
    logic [NUM_STEPS-1:0] stepReady;
    logic [ROUND_W-1:0]   round;
    logic [STEP_W-1:0]    selStep;
    logic                 ldState;
    logic                 done;

    always #5 clk = ~clk;

    keccak_round_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ready     (ready),
        .stepStart (stepStart),
        .stepReady (stepReady),
        .round     (round),
        .selStep   (selStep),
        .ldState   (ldState),
        .done      (done)
    );

    typedef struct {
        int step;
        int rnd;
        int cyc;
    } exp_t;

    exp_t issue_q[$];
    exp_t load_q[$];

    // lo[i]: cycles unit i holds ready low, starting with the Arm cycle
    int lo[NUM_STEPS];
    int low_left[NUM_STEPS];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int exp_issue_cyc = 0;
    int exp_done_cyc = 0;
    int accept_cyc = 0;
    int last_latency = 0;
    int last_done_cyc = 0;
    int done_count = 0;
    bit exp_ready = 1'b1;
    bit done_pending = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic int extra_of(input int s);
        return (lo[s] > 1) ? lo[s] - 1 : 0;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Step unit models: ready stays high while start is accepted, then low lo[i] cycles.
    initial begin
        stepReady = '1;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_STEPS; i++) begin
                if (stepStart[i]) begin
                    low_left[i] = lo[i];
                end else if (low_left[i] > 0) begin
                    stepReady[i] = 1'b0;
                    low_left[i]--;
                end else begin
                    stepReady[i] = 1'b1;
                end
            end
        end
    end

    // Scoreboard: accept pushes the issue sequence, issues push loads, loads pop.
    initial begin
        exp_t e;
        bit   nxt_ready;
        forever begin
            @(negedge clk);
            if (rst) begin
                issue_q.delete();
                load_q.delete();
                exp_ready    = 1'b1;
                done_pending = 1'b0;
            end else begin
                check("ready", ready, exp_ready);
                nxt_ready = exp_ready;
                if (stepStart != '0) begin
                    if (issue_q.size() == 0) begin
                        check("spurious_start", stepStart, 0);
                    end else begin
                        e = issue_q.pop_front();
                        check("start_vec", stepStart, 32'(1) << e.step);
                        check("start_round", round, e.rnd);
                        check("start_cyc", cyc, exp_issue_cyc);
                        load_q.push_back('{e.step, e.rnd, cyc + 3 + extra_of(e.step)});
                    end
                end
                if (ldState) begin
                    check("ld_with_start", stepStart, 0);
                    if (load_q.size() == 0) begin
                        check("spurious_load", ldState, 0);
                    end else begin
                        e = load_q.pop_front();
                        check("ld_sel", selStep, e.step);
                        check("ld_round", round, e.rnd);
                        check("ld_cyc", cyc, e.cyc);
                        exp_issue_cyc = cyc + 1;
                        if (issue_q.size() == 0) begin
                            done_pending = 1'b1;
                            exp_done_cyc = cyc + 1;
                        end
                    end
                end
                if (done) begin
                    check("done_expected", done_pending, 1);
                    check("done_cyc", cyc, exp_done_cyc);
                    check("done_round", round, NUM_ROUNDS - 1);
                    done_pending  = 1'b0;
                    last_latency  = cyc - accept_cyc;
                    last_done_cyc = cyc;
                    done_count++;
                    nxt_ready = 1'b1;
                end
                if (exp_ready && start) begin
                    for (int r = 0; r < NUM_ROUNDS; r++)
                        for (int s = 0; s < NUM_STEPS; s++)
                            issue_q.push_back('{s, r, 0});
                    exp_issue_cyc = cyc + 1;
                    accept_cyc    = cyc;
                    nxt_ready     = 1'b0;
                end
                exp_ready = nxt_ready;
            end
        end
    end

    task automatic wait_done(input int target, input int budget);
        int i = 0;
        while (done_count < target && i < budget) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("done_arrived", done_count >= target, 1);
    endtask

    task automatic run_perm(input int exp_lat, input string tag);
        int base = done_count;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(base + 1, 4000);
        check(tag, last_latency, exp_lat);
    endtask

    initial begin
        int  base;
        int  first_done;
        bit  found;
        for (int i = 0; i < NUM_STEPS; i++) lo[i] = 0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready", ready, 1);
        check("rst_start", stepStart, 0);
        check("rst_ld", ldState, 0);
        check("rst_done", done, 0);
        check("rst_round", round, 0);
        check("rst_sel", selStep, 0);

        // instant units
        run_perm(4 * NUM_STEPS * NUM_ROUNDS + 1, "lat_instant");

        // chi unit holds ready low 6 cycles beyond Arm, every round
        lo[3] = 7;
        run_perm(4 * NUM_STEPS * NUM_ROUNDS + 1 + 6 * NUM_ROUNDS, "lat_slow_chi");
        lo[3] = 0;

        // pi unit shows stale ready while accepting, then low 3 cycles
        lo[2] = 3;
        run_perm(4 * NUM_STEPS * NUM_ROUNDS + 1 + 2 * NUM_ROUNDS, "lat_stale_pi");
        lo[2] = 0;

        // starts while busy are ignored; reset at round 10 step 2
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (30) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (57) @(posedge clk);
        #1 start = 1'b1;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(posedge clk);
            #1;
            if (round == 5'd10 && stepStart[2]) found = 1'b1;
        end
        check("reach_r10_s2", found, 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("mid_rst_ready", ready, 1);
        check("mid_rst_round", round, 0);
        check("mid_rst_start", stepStart, 0);
        check("mid_rst_ld", ldState, 0);
        run_perm(4 * NUM_STEPS * NUM_ROUNDS + 1, "lat_after_rst");

        // start held across Done relaunches immediately
        base = done_count;
        @(posedge clk); #1 start = 1'b1;
        wait_done(base + 1, 4000);
        check("held_lat1", last_latency, 4 * NUM_STEPS * NUM_ROUNDS + 1);
        first_done = last_done_cyc;
        @(posedge clk); #1 start = 1'b0;
        check("relaunch_cyc", accept_cyc, first_done + 1);
        wait_done(base + 2, 4000);
        check("held_lat2", last_latency, 4 * NUM_STEPS * NUM_ROUNDS + 1);
        check("held_done_count", done_count, base + 2);

        repeat (5) @(posedge clk);
        #1;
        check("final_ready", ready, 1);
        check("final_round", round, NUM_ROUNDS - 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keccak_round_sequencer.md
# keccak_round_sequencer

Top-level initiator for the slice-serial Keccak-f permutation core. Drives the start/ready handshake of each step unit (theta, rho, pi, chi, iota/add-round-constant) in fixed order, one at a time, for every round. Supplies the round index to the round-constant step and strobes the state register after each step completes. Sits between the core's external start/ready interface and the per-step responder controllers.

## Interface
- NUM_ROUNDS, 24, rounds per permutation (≥1)
- NUM_STEPS, 5, step units per round, issued in index order 0..NUM_STEPS-1
- ROUND_W, 5, width of round index; must satisfy 2^ROUND_W ≥ NUM_ROUNDS
- STEP_W, 3, width of step index; must satisfy 2^STEP_W ≥ NUM_STEPS
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  permutation request; sampled only in Idle
- ready  out  1  high in Idle only
- stepStart  out  NUM_STEPS  one-hot, one-cycle start pulse to step unit
- stepReady  in  NUM_STEPS  per-unit ready (high while that unit idles)
- round  out  ROUND_W  current round index, 0..NUM_ROUNDS-1
- selStep  out  STEP_W  state-register input mux select
- ldState  out  1  state-register load strobe
- done  out  1  one-cycle pulse at permutation completion

## Operation
- Moore FSM; all outputs decode from present state plus step/round counters.
- States: Idle, Issue, Arm, Wait, Load, Done.
- Idle: ready=1. start=1 → Issue; step and round cleared to 0 on that edge.
- Issue: stepStart[step]=1 → Arm.
- Arm: no outputs; masks the stale ready the unit still shows in the cycle it accepts start → Wait.
- Wait: stepReady[step]=1 → Load, else stay. Other stepReady bits ignored.
- Load: ldState=1, selStep=step.
  - step<NUM_STEPS-1: step+1 → Issue.
  - step=NUM_STEPS-1, round<NUM_ROUNDS-1: step=0, round+1 → Issue.
  - step=NUM_STEPS-1, round=NUM_ROUNDS-1: → Done.
- Done: done=1 → Idle. round holds NUM_ROUNDS-1 until next accepted start.
- start outside Idle ignored; start held high through Done re-launches on the cycle after Done (Idle accepts it).
- selStep equals step in all states; only meaningful when ldState=1.
- round stable from Issue through Load of every step of a round; changes only on Load→Issue round wrap or Idle accept.
- Unused encodings → Idle.

## Timing
- Reset: first rising edge with rst=1 → Idle, step=0, round=0; afterwards ready=1, all other outputs 0. Applies mid-operation; issued pulses are not retracted and step units are not reset by this block.
- Per step: Issue, Arm, Wait (≥1 cycle), Load = 4 cycles + (cycles unit's ready stays low beyond Arm).
- Step whose ready returns high in first Wait cycle: 4 cycles.
- Start accepted at edge E: first stepStart high in cycle after E; done one cycle after final Load; ready one cycle after done.
- Minimum permutation latency (all units instant): 4·NUM_STEPS·NUM_ROUNDS + 1 cycles from accept to done.
- ldState never asserts in the same cycle as stepStart.

## Structure
- Shared package keccak_pkg: NUM_ROUNDS, NUM_STEPS, ROUND_W, STEP_W, step index constants (STEP_THETA=0, STEP_RHO=1, STEP_PI=2, STEP_CHI=3, STEP_IOTA=4), FSM state encoding.
- One sub-module natural: mod_counter (clear, enable, terminal-count flag), instantiated for step and round counters.

## Test plan
- Reset then idle: rst 1 cycle → ready=1, stepStart=0, ldState=0, done=0, round=0.
- Instant units (stepReady all 1), NUM_ROUNDS=24: start 1 cycle → stepStart sequence 00001,00010,00100,01000,10000 ×24; done exactly 481 cycles after accept; round increments 0→23.
- Slow unit: stepReady[3] low for 6 cycles after its start → Wait holds, ldState for step 3 delayed 6 cycles, no other stepStart during wait.
- Stale ready: unit 2 keeps ready=1 in accept cycle, drops next cycle for 3 cycles → no Load until ready returns.
- start pulses during busy and rst at round 10 step 2 → starts ignored; after reset ready=1, round=0; new start restarts from step 0.
- start held high across Done → second permutation begins cycle after Done; done pulses twice, ready=1 only in the single intervening Idle cycle.
